lab7_sos_sw_ctrl: RTL and testbench

Avalon-MM slave controller for the board slide-switch/key inputs feeding the SOS software. Synchronizes and debounces the raw in_port bits and captures rising edges into a sticky register. Raises a maskable level interrupt to the Nios II so software no longer polls the raw switch PIO. Sits on the system interconnect beside the other lab7_sos PIO peripherals.

---
 rtl/lab7_sos_sw_pkg.sv | 8 +
 rtl/lab7_sos_sw_debounce.sv | 37 +++
 rtl/lab7_sos_sw_ctrl.sv | 65 ++++++
 tb/tb_lab7_sos_sw_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lab7_sos_sw_pkg.sv
// lab7_sos_sw_pkg: register map and defaults shared by the switch controller
package lab7_sos_sw_pkg;
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_DBP  = 2'd3;
    localparam int DB_RESET_DEFAULT  = 50000;
endpackage

// File: rtl/lab7_sos_sw_debounce.sv
// lab7_sos_sw_debounce: two-flop synchronizer plus counter debounce for one switch bit
module lab7_sos_sw_debounce #(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            raw,
    input  logic [DB_W-1:0] period,
    input  logic            clr_cnt,
    output logic            stable,
    output logic            rise
);
    logic [1:0]      sync;
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] eff;
    logic            expire;

    assign eff    = (period == '0) ? DB_W'(1) : period;
    // a period write wins over an expiring count so stable never moves that cycle
    assign expire = !clr_cnt && (sync[1] != stable) && (cnt == eff - 1'b1);
    assign rise   = expire && sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (clr_cnt || sync[1] == stable) cnt <= '0;
            else if (expire) begin
                stable <= sync[1];
                cnt    <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/lab7_sos_sw_ctrl.sv
// lab7_sos_sw_ctrl: Avalon-MM switch PIO with debounce, sticky rising-edge capture and maskable irq
module lab7_sos_sw_ctrl
    import lab7_sos_sw_pkg::*;
#(
    parameter int              WIDTH    = 2,
    parameter int              DB_W     = 16,
    parameter logic [DB_W-1:0] DB_RESET = DB_W'(DB_RESET_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] stable, rise, irqmask, edgecap, irqmask_nx, edgecap_nx;
    logic [DB_W-1:0]  dbperiod;
    logic [31:0]      rd_nx;
    logic             wr, clr_cnt;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign clr_cnt   = wr && address == ADDR_DBP;
    assign unused_wd = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        lab7_sos_sw_debounce #(.DB_W(DB_W)) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (in_port[i]),
            .period (dbperiod),
            .clr_cnt(clr_cnt),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // new rises are OR-ed in after the clear so a coincident set survives
    always_comb begin
        irqmask_nx = (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : irqmask;
        edgecap_nx = ((wr && address == ADDR_EDGE) ? edgecap & ~writedata[WIDTH-1:0] : edgecap) | rise;
        rd_nx      = (address == ADDR_DATA) ? 32'(stable)  :
                     (address == ADDR_MASK) ? 32'(irqmask) :
                     (address == ADDR_EDGE) ? 32'(edgecap) : 32'(dbperiod);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask  <= '0;
            edgecap  <= '0;
            dbperiod <= DB_RESET;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            irqmask  <= irqmask_nx;
            edgecap  <= edgecap_nx;
            if (clr_cnt) dbperiod <= writedata[DB_W-1:0];
            readdata <= rd_nx;
            irq      <= |(edgecap_nx & irqmask_nx);
        end
    end
endmodule

// File: tb/tb_lab7_sos_sw_ctrl.sv
// tb_lab7_sos_sw_ctrl: directed scoreboard bench for the debounced switch controller
module tb_lab7_sos_sw_ctrl;
    import lab7_sos_sw_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [1:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    lab7_sos_sw_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        push(tag, {31'b0, exp});
        pop_chk({31'b0, irq});
    endtask

    task automatic do_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        push(tag, exp);
        tick();
        pop_chk(readdata);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        push("rst_readdata", 0);
        pop_chk(readdata);
        chk_irq("rst_irq", 1'b0);
        reset_n = 1'b1;
        tick();
        do_read(ADDR_DATA, "rst_data", 0);
        do_read(ADDR_MASK, "rst_mask", 0);
        do_read(ADDR_EDGE, "rst_edge", 0);
        do_read(ADDR_DBP, "rst_dbp", 50000);
        chk_irq("rst_irq2", 1'b0);

        // bit0 rise with period 4: stable at edge 6, readdata one edge later
        do_write(ADDR_DBP, 4);
        address = ADDR_DATA;
        in_port = 2'b01;
        for (int i = 1; i <= 7; i++) begin
            push($sformatf("data_lat_%0d", i), (i == 7) ? 1 : 0);
            tick();
            pop_chk(readdata);
        end
        do_read(ADDR_EDGE, "edge_after_rise", 1);
        chk_irq("irq_masked_off", 1'b0);

        // 3-cycle glitch on bit1 must be rejected
        in_port = 2'b11;
        repeat (3) tick();
        in_port = 2'b01;
        repeat (6) tick();
        do_read(ADDR_DATA, "glitch_data", 1);
        do_read(ADDR_EDGE, "glitch_edge", 1);
        chk_irq("glitch_irq", 1'b0);

        do_write(ADDR_MASK, 1);
        chk_irq("irq_mask_enable", 1'b1);
        do_write(ADDR_EDGE, 1);
        chk_irq("irq_after_clear", 1'b0);
        do_read(ADDR_EDGE, "edge_after_clear", 0);

        // falling edge does not capture; fresh rise raises irq on its capture edge
        in_port = 2'b00;
        repeat (10) tick();
        do_read(ADDR_DATA, "fall_data", 0);
        do_read(ADDR_EDGE, "fall_edge", 0);
        chk_irq("fall_irq", 1'b0);
        in_port = 2'b01;
        repeat (5) tick();
        chk_irq("rise_irq_pre", 1'b0);
        tick();
        chk_irq("rise_irq", 1'b1);

        // clear coinciding with a new rise: set wins
        in_port = 2'b00;
        repeat (10) tick();
        chk_irq("pending_irq", 1'b1);
        in_port = 2'b01;
        repeat (5) tick();
        do_write(ADDR_EDGE, 1);
        chk_irq("setclr_irq", 1'b1);
        do_read(ADDR_EDGE, "setclr_edge", 1);

        do_write(ADDR_MASK, 0);
        chk_irq("mask_off_irq", 1'b0);
        do_read(ADDR_EDGE, "mask_off_edge", 1);
        do_read(ADDR_MASK, "mask_read", 0);

        // reset in the middle of bit1 debounce (counter at 2 of 4)
        do_read(ADDR_DBP, "dbp_read", 4);
        in_port = 2'b11;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        push("midrst_readdata", 0);
        pop_chk(readdata);
        chk_irq("midrst_irq", 1'b0);
        tick();
        reset_n = 1'b1;
        do_read(ADDR_DBP, "midrst_dbp", 50000);
        do_read(ADDR_DATA, "midrst_data", 0);
        do_read(ADDR_MASK, "midrst_mask", 0);
        do_read(ADDR_EDGE, "midrst_edge", 0);
        chk_irq("midrst_irq2", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
